ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends command bytes to the keyboard, such as LED set (0xED), echo, or reset (0xFF), in the opposite direction to the keyboard scan-code receive path. It sits beside KeyboardAdapter in top on the clk_11 domain and is driven by mmu through a start/busy/done handshake. It drives the open-drain PS/2 lines through drive-low enables; the top-level tristate maps each enable to 0 when asserted and Z otherwise.

---
 rtl/ps2_host_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, shifts a
// command byte plus odd parity out on device-generated clock falls, then checks the ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 1200,
    parameter int unsigned TIMEOUT_CYCLES = 166000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] send_data,
    input  logic       send_start,
    output logic       busy,
    output logic       send_done,
    output logic       send_error,
    input  logic       ps2clk_i,
    input  logic       ps2data_i,
    output logic       ps2clk_drive_low,
    output logic       ps2data_drive_low
);

    localparam int unsigned InhW  = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);

    localparam logic [InhW-1:0]  InhLast  = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StData,
        StParity,
        StStop,
        StRelease
    } state_e;

    // Synchronizers and clock filter
    logic             clk_meta_q, clk_sync_q;
    logic             dat_meta_q, dat_sync_q;
    logic             fclk_q, fclk_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             fall;

    // Transmit FSM state
    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            clk_low_q, clk_low_d;
    logic            dat_low_q, dat_low_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [2:0]      idx_q, idx_d;
    logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic            to_active;

    // Two-flop synchronizers for both raw PS/2 lines; idle level is 1
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2clk_i;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2data_i;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Clock filter: flip fclk only after FILTER_LEN consecutive samples of the new level
    always_comb begin
        fclk_d     = fclk_q;
        filt_cnt_d = filt_cnt_q;
        if (clk_sync_q == fclk_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FiltLast) begin
            fclk_d     = clk_sync_q;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + FiltW'(1);
        end
    end

    // Falling edge of the filtered clock, seen in the cycle fclk is about to drop
    assign fall = fclk_q & ~fclk_d;

    // Filter state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            fclk_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            fclk_q     <= fclk_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign to_active = (state_q != StIdle) && (state_q != StInhibit);

    // Next-state and output logic for the transmit sequence
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        clk_low_d = clk_low_q;
        dat_low_d = dat_low_q;
        shift_d   = shift_q;
        par_d     = par_q;
        idx_d     = idx_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;

        unique case (state_q)
            StIdle: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                if (send_start) begin
                    shift_d   = send_data;
                    par_d     = ~^send_data;
                    busy_d    = 1'b1;
                    clk_low_d = 1'b1;
                    inh_cnt_d = '0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (inh_cnt_q == InhLast) begin
                    // Start bit goes out as the clock is released
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = StReq;
                end else begin
                    inh_cnt_d = inh_cnt_q + InhW'(1);
                end
            end
            StReq: begin
                if (fall) begin
                    dat_low_d = ~shift_q[0];
                    idx_d     = 3'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (fall) begin
                    if (idx_q == 3'd7) begin
                        dat_low_d = ~par_q;
                        state_d   = StParity;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        dat_low_d = ~shift_q[idx_q + 3'd1];
                    end
                end
            end
            StParity: begin
                if (fall) begin
                    dat_low_d = 1'b0;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    if (!dat_sync_q) begin
                        state_d = StRelease;
                    end else begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            StRelease: begin
                if (fclk_q && dat_sync_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Timeout overrides whatever the state logic decided this cycle
        if (to_active) begin
            to_cnt_d = to_cnt_q + ToW'(1);
            if (to_cnt_q == ToLast) begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                done_d    = 1'b0;
                error_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = StIdle;
            end
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            idx_q     <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            clk_low_q <= clk_low_d;
            dat_low_q <= dat_low_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            idx_q     <= idx_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign busy              = busy_q;
    assign send_done         = done_q;
    assign send_error        = error_q;
    assign ps2clk_drive_low  = clk_low_q;
    assign ps2data_drive_low = dat_low_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model plus a PS/2 device that clocks frames in.
module tb_ps2_host_tx;

    localparam int unsigned InhibitCycles = 8;
    localparam int unsigned TimeoutCycles = 3000;
    localparam int unsigned FilterLen     = 2;

    localparam int ModeAck    = 0;
    localparam int ModeNoAck  = 1;
    localparam int ModeSilent = 2;
    localparam int ModeInject = 3;
    localparam int ModeAbort  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] send_data;
    logic       send_start;
    logic       busy;
    logic       send_done;
    logic       send_error;
    logic       ps2clk_i;
    logic       ps2data_i;
    logic       ps2clk_drive_low;
    logic       ps2data_drive_low;
    logic       dev_clk_low;
    logic       dev_dat_low;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [9:0] exp_frame_q[$];
    logic [1:0] exp_outcome_q[$];
    logic [1:0] mon_exp;

    // Wired-AND open-drain lines
    assign ps2clk_i  = ~(ps2clk_drive_low | dev_clk_low);
    assign ps2data_i = ~(ps2data_drive_low | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(InhibitCycles),
        .TIMEOUT_CYCLES(TimeoutCycles),
        .FILTER_LEN    (FilterLen)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .send_data        (send_data),
        .send_start       (send_start),
        .busy             (busy),
        .send_done        (send_done),
        .send_error       (send_error),
        .ps2clk_i         (ps2clk_i),
        .ps2data_i        (ps2data_i),
        .ps2clk_drive_low (ps2clk_drive_low),
        .ps2data_drive_low(ps2data_drive_low)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Odd parity bit: set when the byte has an even number of ones
    function automatic logic odd_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 0;
    endfunction

    // Completion monitor: every done/error pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (send_done || send_error) begin
            check("pulse_excl", 32'(send_done & send_error), 32'(0));
            check("pulse_busy", 32'(busy), 32'(0));
            check("pulse_lines", 32'({ps2clk_drive_low, ps2data_drive_low}), 32'(0));
            if (exp_outcome_q.size() == 0) begin
                check("pulse_unexpected", 32'({send_done, send_error}), 32'(0));
            end else begin
                mon_exp = exp_outcome_q.pop_front();
                check("outcome", 32'({send_done, send_error}), 32'(mon_exp));
            end
        end
    end

    // Device side: 11 clock pulses of 40 cycles, data sampled at each rising edge
    task automatic dev_run(input bit ack, input int abort_at, input bit inject,
                           output logic [9:0] got, output bit aborted);
        got     = '0;
        aborted = 1'b0;
        check("start_bit", 32'(ps2data_i), 32'(0));
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && ack) begin
                dev_dat_low = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            if (i == abort_at) begin
                rst = 1'b0;
                @(negedge clk);
                check("rst_lines", 32'({ps2clk_drive_low, ps2data_drive_low}), 32'(0));
                check("rst_busy", 32'(busy), 32'(0));
                check("rst_pulses", 32'({send_done, send_error}), 32'(0));
                rst         = 1'b1;
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                aborted     = 1'b1;
                repeat (40) @(negedge clk);
                return;
            end
            if (inject && i == 3) begin
                // Busy host must ignore this request
                send_data  = 8'h55;
                send_start = 1'b1;
                @(negedge clk);
                send_start = 1'b0;
                send_data  = 8'h00;
                repeat (9) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
            if (i < 10) got[i] = ps2data_i;
            dev_clk_low = 1'b0;
            if (inject && i == 5) begin
                repeat (10) @(negedge clk);
                dev_clk_low = 1'b1;
                @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (9) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic do_send(input logic [7:0] b, input int mode);
        logic [9:0] got;
        logic [9:0] exp_f;
        bit         aborted;
        int         c;
        if (mode != ModeSilent) exp_frame_q.push_back({1'b1, odd_par(b), b});
        if (mode == ModeAck || mode == ModeInject) exp_outcome_q.push_back(2'b10);
        if (mode == ModeNoAck || mode == ModeSilent) exp_outcome_q.push_back(2'b01);

        send_data  = b;
        send_start = 1'b1;
        @(negedge clk);
        send_start = 1'b0;
        send_data  = ~b;
        check("accept_busy", 32'(busy), 32'(1));

        c = 0;
        while (ps2clk_drive_low && c < 100) begin
            c++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(c), 32'(InhibitCycles));
        check("start_drive", 32'(ps2data_drive_low), 32'(1));

        if (mode == ModeSilent) begin
            c = 0;
            while (!send_error && c < int'(TimeoutCycles) + 100) begin
                @(negedge clk);
                c++;
            end
            check("timeout_len", 32'(c), 32'(TimeoutCycles));
            check("timeout_lines", 32'({ps2clk_drive_low, ps2data_drive_low}), 32'(0));
            check("timeout_busy", 32'(busy), 32'(0));
            @(negedge clk);
            return;
        end

        repeat (10) @(negedge clk);
        dev_run(mode != ModeNoAck, (mode == ModeAbort) ? 3 : -1, mode == ModeInject,
                got, aborted);
        exp_f = exp_frame_q.pop_front();
        if (!aborted) check("frame", 32'(got), 32'(exp_f));

        c = 0;
        while (busy && c < 500) begin
            c++;
            @(negedge clk);
        end
        check("busy_release", 32'(busy), 32'(0));
    endtask

    initial begin
        rst         = 1'b0;
        send_start  = 1'b0;
        send_data   = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy0", 32'(busy), 32'(0));
        check("rst_done0", 32'(send_done), 32'(0));
        check("rst_err0", 32'(send_error), 32'(0));
        check("rst_clk_low0", 32'(ps2clk_drive_low), 32'(0));
        check("rst_dat_low0", 32'(ps2data_drive_low), 32'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        do_send(8'hED, ModeAck);
        do_send(8'h00, ModeAck);
        do_send(8'hFF, ModeAck);
        do_send(8'hF4, ModeAck);
        do_send(8'hA3, ModeNoAck);
        do_send(8'h3C, ModeSilent);
        do_send(8'hA3, ModeInject);
        do_send(8'h96, ModeAbort);
        do_send(8'h5A, ModeAck);

        repeat (20) @(negedge clk);
        check("outcomes_drained", 32'(exp_outcome_q.size()), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
